// File: rtl/score_bcd_ctrl.sv
// 4-digit BCD score keeper: serial digit-per-cycle add, atomic commit, saturation at 9999.
// Optional high-score tracking is built when HISCORE_EN is defined.
module score_bcd_ctrl #(
  parameter bit CLAMP_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add_valid,
  output logic       add_ready,
  input  logic [7:0] add_pts,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [3:0] score_3,
  output logic [3:0] score_4,
  output logic       busy,
  output logic       done,
  output logic       saturated
`ifdef HISCORE_EN
  ,
  output logic [3:0] hi_1,
  output logic [3:0] hi_2,
  output logic [3:0] hi_3,
  output logic [3:0] hi_4
`endif
);

  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, ADD3, COMMIT} state_t;

  state_t           state, state_nx;
  logic [3:0][3:0]  score;
  logic [3:0][3:0]  work;
  logic [3:0]       pts_lo, pts_hi;
  logic             carry;

  logic             accept;
  logic [1:0]       idx;
  logic [3:0]       cur_pts;
  logic [4:0]       sum;
  logic             over;
  logic [3:0]       dig;
  logic [15:0]      new_score;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    if (d > 4'd9) return CLAMP_INVALID ? 4'd9 : 4'd0;
    return d;
  endfunction

  assign add_ready = (state == IDLE) && !clear;
  assign busy      = (state != IDLE);
  assign accept    = add_valid && add_ready;

  assign score_1 = score[0];
  assign score_2 = score[1];
  assign score_3 = score[2];
  assign score_4 = score[3];

  always_comb begin
    state_nx = state;
    idx      = 2'd0;
    cur_pts  = 4'd0;
    case (state)
      IDLE:    if (accept) state_nx = ADD0;
      ADD0:    begin state_nx = ADD1; idx = 2'd0; cur_pts = pts_lo; end
      ADD1:    begin state_nx = ADD2; idx = 2'd1; cur_pts = pts_hi; end
      ADD2:    begin state_nx = ADD3; idx = 2'd2; end
      ADD3:    begin state_nx = COMMIT; idx = 2'd3; end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  // 4-bit wrap of (sum - 10) gives the correct digit for sums 10..19
  assign sum       = {1'b0, work[idx]} + {1'b0, cur_pts} + {4'd0, carry};
  assign over      = (sum > 5'd9);
  assign dig       = over ? (sum[3:0] - 4'd10) : sum[3:0];
  assign new_score = carry ? 16'h9999 : work;

`ifdef HISCORE_EN
  logic [3:0][3:0] hi;
  assign hi_1 = hi[0];
  assign hi_2 = hi[1];
  assign hi_3 = hi[2];
  assign hi_4 = hi[3];

  // Valid BCD orders the same as binary, so a plain 16-bit compare suffices
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
    end else if (!clear && state == COMMIT && new_score > hi) begin
      hi <= new_score;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      score     <= '0;
      work      <= '0;
      pts_lo    <= '0;
      pts_hi    <= '0;
      carry     <= 1'b0;
      saturated <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (clear) begin
        score     <= '0;
        saturated <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              work   <= score;
              pts_lo <= clamp_digit(add_pts[3:0]);
              pts_hi <= clamp_digit(add_pts[7:4]);
              carry  <= 1'b0;
            end
          end
          ADD0, ADD1, ADD2, ADD3: begin
            work[idx] <= dig;
            carry     <= over;
          end
          COMMIT: begin
            score <= new_score;
            done  <= 1'b1;
            if (carry) saturated <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
